// File: rtl/wfg_core_pulse_gen.sv
// Subcycle/sync timing engine for the waveform-generator core, with shadowed period config.
// Optional WFG_CORE_SYNC_CNT_EN adds a 16-bit count of sync pulses since start.
module wfg_core_pulse_gen #(
  parameter int SUBW  = 16,
  parameter int SYNCW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ctrl_en_q_i,
  input  logic [SUBW-1:0]  cfg_subcycle_q_i,
  input  logic [SYNCW-1:0] cfg_sync_q_i,
  output logic             wfg_core_subcycle_o,
  output logic             wfg_core_sync_o,
  output logic             wfg_core_start_o,
  output logic [SYNCW-1:0] wfg_core_subcycle_cnt_o,
  output logic             wfg_core_active_o
`ifdef WFG_CORE_SYNC_CNT_EN
  ,
  output logic [15:0]      wfg_core_sync_cnt_o
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SUBW-1:0]  sc_cnt_q, sc_cnt_d;
  logic [SYNCW-1:0] sy_cnt_q, sy_cnt_d;
  logic [SUBW-1:0]  sub_sh_q, sub_sh_d;
  logic [SYNCW-1:0] sync_sh_q, sync_sh_d;
  logic             subcycle_q, subcycle_d;
  logic             sync_q, sync_d;
  logic             start_q, start_d;
`ifdef WFG_CORE_SYNC_CNT_EN
  logic [15:0]      sync_cnt_q, sync_cnt_d;
`endif

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_d    = state_q;
    sc_cnt_d   = sc_cnt_q;
    sy_cnt_d   = sy_cnt_q;
    sub_sh_d   = sub_sh_q;
    sync_sh_d  = sync_sh_q;
    subcycle_d = 1'b0;
    sync_d     = 1'b0;
    start_d    = 1'b0;
`ifdef WFG_CORE_SYNC_CNT_EN
    sync_cnt_d = sync_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        sc_cnt_d  = '0;
        sy_cnt_d  = '0;
        sub_sh_d  = '0;
        sync_sh_d = '0;
`ifdef WFG_CORE_SYNC_CNT_EN
        sync_cnt_d = '0;
`endif
        if (ctrl_en_q_i) begin
          state_d    = ST_RUN;
          sub_sh_d   = cfg_subcycle_q_i;
          sync_sh_d  = cfg_sync_q_i;
          subcycle_d = 1'b1;
          sync_d     = 1'b1;
          start_d    = 1'b1;
        end
      end
      ST_RUN: begin
        if (!ctrl_en_q_i) begin
          // Disable takes priority over any boundary falling on this edge.
          state_d   = ST_IDLE;
          sc_cnt_d  = '0;
          sy_cnt_d  = '0;
          sub_sh_d  = '0;
          sync_sh_d = '0;
`ifdef WFG_CORE_SYNC_CNT_EN
          sync_cnt_d = '0;
`endif
        end else if (sc_cnt_q != sub_sh_q) begin
          sc_cnt_d = sc_cnt_q + SUBW'(1);
        end else begin
          sc_cnt_d   = '0;
          subcycle_d = 1'b1;
          if (sy_cnt_q == sync_sh_q) begin
            // Sync boundary is the only point where new config is adopted.
            sy_cnt_d  = '0;
            sync_d    = 1'b1;
            sub_sh_d  = cfg_subcycle_q_i;
            sync_sh_d = cfg_sync_q_i;
`ifdef WFG_CORE_SYNC_CNT_EN
            sync_cnt_d = sync_cnt_q + 16'd1;
`endif
          end else begin
            sy_cnt_d = sy_cnt_q + SYNCW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sc_cnt_q   <= '0;
      sy_cnt_q   <= '0;
      sub_sh_q   <= '0;
      sync_sh_q  <= '0;
      subcycle_q <= 1'b0;
      sync_q     <= 1'b0;
      start_q    <= 1'b0;
`ifdef WFG_CORE_SYNC_CNT_EN
      sync_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sc_cnt_q   <= sc_cnt_d;
      sy_cnt_q   <= sy_cnt_d;
      sub_sh_q   <= sub_sh_d;
      sync_sh_q  <= sync_sh_d;
      subcycle_q <= subcycle_d;
      sync_q     <= sync_d;
      start_q    <= start_d;
`ifdef WFG_CORE_SYNC_CNT_EN
      sync_cnt_q <= sync_cnt_d;
`endif
    end
  end

  assign wfg_core_subcycle_o     = subcycle_q;
  assign wfg_core_sync_o         = sync_q;
  assign wfg_core_start_o        = start_q;
  assign wfg_core_subcycle_cnt_o = sy_cnt_q;
  assign wfg_core_active_o       = (state_q == ST_RUN);
`ifdef WFG_CORE_SYNC_CNT_EN
  assign wfg_core_sync_cnt_o     = sync_cnt_q;
`endif

endmodule

// File: tb/tb_wfg_core_pulse_gen.sv
// Randomized bench for wfg_core_pulse_gen against an offset-within-period model.
// Build with WFG_CORE_SYNC_CNT_EN defined to also exercise the sync counter.
module tb_wfg_core_pulse_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] cfg_sub = '0;
  logic [7:0]  cfg_sync = '0;
  logic        sub_o, sync_o, start_o, active_o;
  logic [7:0]  cnt_o;
`ifdef WFG_CORE_SYNC_CNT_EN
  logic [15:0] scnt_o;
`endif

  int total = 0;
  int bad = 0;

  wfg_core_pulse_gen #(.SUBW(16), .SYNCW(8)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .ctrl_en_q_i             (en),
    .cfg_subcycle_q_i        (cfg_sub),
    .cfg_sync_q_i            (cfg_sync),
    .wfg_core_subcycle_o     (sub_o),
    .wfg_core_sync_o         (sync_o),
    .wfg_core_start_o        (start_o),
    .wfg_core_subcycle_cnt_o (cnt_o),
    .wfg_core_active_o       (active_o)
`ifdef WFG_CORE_SYNC_CNT_EN
    ,
    .wfg_core_sync_cnt_o     (scnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: position m_o (clocks) inside the current sync period of length (sub+1)*(sync+1).
  bit          m_run = 1'b0;
  bit          m_start = 1'b0;
  int          m_o = 0;
  int          m_sub = 0;
  int          m_sync = 0;
  logic [15:0] m_ns = '0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (!en) begin
        m_run = 1'b0; m_start = 1'b0; m_o = 0; m_ns = '0;
      end else if (!m_run) begin
        m_run = 1'b1; m_start = 1'b1; m_o = 0; m_ns = '0;
        m_sub = int'(cfg_sub); m_sync = int'(cfg_sync);
      end else begin
        m_start = 1'b0;
        m_o++;
        if (m_o == (m_sub + 1) * (m_sync + 1)) begin
          m_o = 0;
          m_sub = int'(cfg_sub);
          m_sync = int'(cfg_sync);
          m_ns = m_ns + 16'd1;
        end
      end
    end
  end

  always @(negedge rst_n) begin
    m_run = 1'b0; m_start = 1'b0; m_o = 0; m_ns = '0;
  end

  // Continuous comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    chk("subcycle", 32'(sub_o), 32'(m_run && ((m_o % (m_sub + 1)) == 0)));
    chk("sync", 32'(sync_o), 32'(m_run && (m_o == 0)));
    chk("start", 32'(start_o), 32'(m_run && m_start));
    chk("active", 32'(active_o), 32'(m_run));
    chk("subcycle_cnt", 32'(cnt_o), m_run ? 32'(m_o / (m_sub + 1)) : 32'd0);
`ifdef WFG_CORE_SYNC_CNT_EN
    chk("sync_cnt", 32'(scnt_o), m_run ? 32'(m_ns) : 32'd0);
`endif
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_subcycle"}, 32'(sub_o), 32'd0);
    chk({tag, "_sync"}, 32'(sync_o), 32'd0);
    chk({tag, "_start"}, 32'(start_o), 32'd0);
    chk({tag, "_active"}, 32'(active_o), 32'd0);
    chk({tag, "_cnt"}, 32'(cnt_o), 32'd0);
  endtask

  logic [15:0] exp_sub16, exp_sync16, exp_cnt16, exp_start16;
  logic [23:0] exp_sub24, exp_sync24;

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic cadence: sub=3, sync=1
    exp_sub16   = 16'h1111;
    exp_sync16  = 16'h0101;
    exp_cnt16   = 16'hF0F0;
    exp_start16 = 16'h0001;
    cfg_sub = 16'd3; cfg_sync = 8'd1; en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("cad_subcycle", 32'(sub_o), 32'(exp_sub16[k]));
      chk("cad_sync", 32'(sync_o), 32'(exp_sync16[k]));
      chk("cad_cnt", 32'(cnt_o), 32'(exp_cnt16[k]));
      chk("cad_start", 32'(start_o), 32'(exp_start16[k]));
    end
    en = 1'b0;
    repeat (2) @(negedge clk);

    // Degenerate config: everything held high
    cfg_sub = 16'd0; cfg_sync = 8'd0; en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("deg_subcycle", 32'(sub_o), 32'd1);
      chk("deg_sync", 32'(sync_o), 32'd1);
      chk("deg_active", 32'(active_o), 32'd1);
      chk("deg_start", 32'(start_o), (k == 0) ? 32'd1 : 32'd0);
    end
    en = 1'b0;
    repeat (2) @(negedge clk);

    // Shadowing: sub changes 3->1 mid-period, takes effect at the 16-clk boundary
    exp_sub24  = 24'h551111;
    exp_sync24 = 24'h010000;
    cfg_sub = 16'd3; cfg_sync = 8'd3; en = 1'b1;
    @(negedge clk);
    repeat (5) @(negedge clk);
    cfg_sub = 16'd1;
    for (int k = 6; k < 24; k++) begin
      @(negedge clk);
      chk("shadow_subcycle", 32'(sub_o), 32'(exp_sub24[k]));
      chk("shadow_sync", 32'(sync_o), 32'(exp_sync24[k]));
    end
    en = 1'b0;
    repeat (2) @(negedge clk);

    // Disable exactly on the subcycle boundary, then restart 2 clks later
    cfg_sub = 16'd3; cfg_sync = 8'd1; en = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk_all_zero("disable");
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    chk("restart_start", 32'(start_o), 32'd1);
    chk("restart_sync", 32'(sync_o), 32'd1);
    chk("restart_active", 32'(active_o), 32'd1);

    // Asynchronous reset between edges
    cfg_sub = 16'd2; cfg_sync = 8'd2;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_restart_start", 32'(start_o), 32'd1);
    chk("rst_restart_active", 32'(active_o), 32'd1);

    // Randomized traffic: enable toggles, config writes, rare async resets
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (en) begin
        if ($urandom_range(0, 99) == 0) en = 1'b0;
      end else if ($urandom_range(0, 4) == 0) begin
        en = 1'b1;
      end
      if ($urandom_range(0, 24) == 0) begin
        cfg_sub  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom_range(0, 5));
        cfg_sync = 8'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    en = 1'b0;
    repeat (2) @(negedge clk);

`ifdef WFG_CORE_SYNC_CNT_EN
    // Sync counter wrap with a sync pulse every clock
    cfg_sub = 16'd0; cfg_sync = 8'd0; en = 1'b1;
    @(negedge clk);
    chk("scnt_first", 32'(scnt_o), 32'd0);
    repeat (65535) @(negedge clk);
    chk("scnt_max", 32'(scnt_o), 32'h0000FFFF);
    @(negedge clk);
    chk("scnt_wrap", 32'(scnt_o), 32'd0);
    @(negedge clk);
    chk("scnt_after_wrap", 32'(scnt_o), 32'd1);
    en = 1'b0;
    @(negedge clk);
    chk("scnt_idle", 32'(scnt_o), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
